sayuru_sa: RTL and testbench
============================

# sayuru_sa

Parametrised N-way set-associative, write-back, write-allocate data cache sitting between the core's data memory port and the memory/interconnect port; the generalisation of the direct-mapped Sayuru cache. Lines are one data word; associativity and set count are parameters, victims are chosen by a per-set round-robin pointer, and the block exports the same seven 32-bit performance counters plus a counter-enable.

## Interface
- ADDR_WIDTH, 16, byte address width
- DATA_WIDTH, 32, word width; power of two, ≥16
- SETS, 16, number of sets; power of two, ≥2
- WAYS, 2, ways per set; power of two, 1..8 (1 = direct-mapped)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data_req_i / in_data_gnt_o / in_data_rvalid_o  in/out/out  1  core-side handshake
- in_data_addr_i  in  ADDR_WIDTH  byte address
- in_data_we_i  in  1  1 = store
- in_data_be_i  in  DATA_WIDTH/8  byte enables
- in_data_wdata_i / in_data_rdata_o  in/out  DATA_WIDTH  store data / load data
- out_data_req_o / out_data_gnt_i / out_data_rvalid_i  out/in/in  1  memory-side handshake
- out_data_addr_o  out  ADDR_WIDTH; out_data_we_o  out  1; out_data_be_o  out  DATA_WIDTH/8
- out_data_wdata_o / out_data_rdata_i  out/in  DATA_WIDTH
- count_en_i  in  1  counters advance only when high
- trans_count, hit_load_count, hit_store_count, miss_load_count, miss_store_count, writeback_load_count, writeback_store_count  out  32 each

## Operation
- Address split: OFF = log2(DATA_WIDTH/8) low bits ignored; index = next log2(SETS) bits; tag = remaining bits.
- Per way per set: valid, dirty, tag, data. Per set: round-robin victim pointer, log2(WAYS) bits (absent when WAYS=1).
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESPOND.
- IDLE: in_data_gnt_o = in_data_req_i (combinational); on grant latch addr/we/be/wdata, go LOOKUP. gnt is 0 in all other states.
- LOOKUP: tag compare all ways. Hit: load reads way data; store merges wdata by be, sets dirty; go RESPOND. Miss: victim = first invalid way (lowest index), else way at pointer; if victim valid and dirty go WB_REQ, else FILL_REQ.
- WB_REQ: out_data_req_o=1, we=1, be=all ones, addr={victim tag, index, OFF zeros}, wdata=victim data; hold until out_data_gnt_i, then WB_WAIT. WB_WAIT: on out_data_rvalid_i go FILL_REQ.
- FILL_REQ: req=1, we=0, addr={latched tag, index, zeros}, be=all ones; hold until gnt, then FILL_WAIT. FILL_WAIT: on rvalid write out_data_rdata_i into victim, valid=1, tag updated; load: dirty=0, rdata = fill data; store: merge wdata by be, dirty=1. Advance round-robin pointer (mod WAYS) only when an already-valid way was replaced. Go RESPOND.
- RESPOND: in_data_rvalid_o=1 for one cycle (loads and stores; rdata meaningful for loads only), return to IDLE.
- Counters (when count_en_i): trans_count +1 per grant; hit/miss load/store +1 in LOOKUP; writeback_load/store +1 on entering WB_REQ by op type. All wrap modulo 2^32.
- out_data_rvalid_i outside WB_WAIT/FILL_WAIT is ignored.

## Timing
- Reset (any state): state=IDLE; all valid, dirty, pointers, counters cleared; in_data_gnt_o driven only by comb rule (0 unless req); in_data_rvalid_o=0, in_data_rdata_o=0, out_data_req_o=0, out_data_we_o=0, out_data_addr_o=0, out_data_be_o=0, out_data_wdata_o=0. In-flight transaction abandoned, dirty data discarded, no rvalid issued.
- Hit: grant cycle T, LOOKUP T+1, rvalid T+2. Back-to-back hits: next grant at T+3 (one transaction per 3 cycles).
- Clean miss: memory req at T+2; rvalid one cycle after the FILL_WAIT cycle receiving memory rvalid.
- Dirty miss: writeback fully completes (rvalid) before fill request is issued; out_data_req_o deasserted for at least the cycle spent in WB_WAIT.
- out_data_* stable while out_data_req_o=1 and gnt not yet seen; req drops the cycle after gnt.
- Memory gnt/rvalid latency arbitrary (≥0 wait cycles gnt, ≥1 cycle gnt→rvalid).

## Test plan
- Reset, load 0x0040 with memory returning 0xDEADBEEF -> one fill at 0x0040, rvalid rdata=0xDEADBEEF; repeat load -> hit at T+2, no memory req; miss_load=1, hit_load=1, trans=2.
- Store be=4'b0011 wdata=0x0000AAAA to 0x0040 (cached 0xDEADBEEF) -> hit, later load returns 0xDEADAAAA, no memory write.
- WAYS=2, SETS=16: dirty 0x0040, then loads 0x0080, 0x00C0 (same set) -> second fills free way, third evicts way 0: write 0x0040 data 0xDEADAAAA before fill of 0x00C0; writeback_load=1.
- Memory gnt delayed 5 cycles, rvalid 3 cycles later -> out_data_* stable throughout, in_data_gnt_o low for new requests while busy.
- Assert rst during FILL_WAIT -> no in_data_rvalid_o, out_data_req_o=0 next cycle, all counters 0, prior hit address now misses.
- count_en_i=0 for 4 transactions -> all counters unchanged; WAYS=1 build passes the direct-mapped eviction case.

Source files
------------

// File: rtl/sayuru_sa.sv
// sayuru_sa: N-way set-associative, write-back, write-allocate data cache
// with per-set round-robin replacement and seven performance counters.
module sayuru_sa #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_data_req_i,
    output logic                    in_data_gnt_o,
    output logic                    in_data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   in_data_addr_i,
    input  logic                    in_data_we_i,
    input  logic [DATA_WIDTH/8-1:0] in_data_be_i,
    input  logic [DATA_WIDTH-1:0]   in_data_wdata_i,
    output logic [DATA_WIDTH-1:0]   in_data_rdata_o,
    output logic                    out_data_req_o,
    input  logic                    out_data_gnt_i,
    input  logic                    out_data_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   out_data_addr_o,
    output logic                    out_data_we_o,
    output logic [DATA_WIDTH/8-1:0] out_data_be_o,
    output logic [DATA_WIDTH-1:0]   out_data_wdata_o,
    input  logic [DATA_WIDTH-1:0]   out_data_rdata_i,
    input  logic                    count_en_i,
    output logic [31:0]             trans_count,
    output logic [31:0]             hit_load_count,
    output logic [31:0]             hit_store_count,
    output logic [31:0]             miss_load_count,
    output logic [31:0]             miss_store_count,
    output logic [31:0]             writeback_load_count,
    output logic [31:0]             writeback_store_count
);

    localparam int BEW = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BEW);
    localparam int IW  = $clog2(SETS);
    localparam int TW  = ADDR_WIDTH - OFF - IW;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESPOND
    } state_t;

    state_t state_q, state_d;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [TW-1:0]         tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
    logic [WW-1:0]         ptr_q   [SETS];

    logic [ADDR_WIDTH-OFF-1:0] waddr_q;
    logic                      we_q;
    logic [BEW-1:0]            be_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [WW-1:0]             way_q;
    logic                      repl_q;
    logic [31:0]               cnt_q [7];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          grant;
    logic          hit;
    logic [WW-1:0] hit_way;
    logic [WW-1:0] vic_way;
    logic          vic_free;
    logic          vic_dirty;
    logic [6:0]    inc;
    logic          unused_addr_lo;

    function automatic logic [DATA_WIDTH-1:0] merge_be(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [BEW-1:0]        be);
        merge_be = old_w;
        for (int unsigned b = 0; b < BEW; b++) begin
            if (be[b]) merge_be[8*b +: 8] = new_w[8*b +: 8];
        end
    endfunction

    assign idx            = waddr_q[IW-1:0];
    assign tag            = waddr_q[ADDR_WIDTH-OFF-1:IW];
    assign grant          = (state_q == IDLE) && in_data_req_i;
    assign unused_addr_lo = ^in_data_addr_i[OFF-1:0];

    // Counter increment strobes: 0 trans, 1/2 hit ld/st, 3/4 miss ld/st, 5/6 writeback ld/st
    assign inc[0] = grant;
    assign inc[1] = (state_q == LOOKUP) &&  hit && !we_q;
    assign inc[2] = (state_q == LOOKUP) &&  hit &&  we_q;
    assign inc[3] = (state_q == LOOKUP) && !hit && !we_q;
    assign inc[4] = (state_q == LOOKUP) && !hit &&  we_q;
    assign inc[5] = (state_q == LOOKUP) && !hit && vic_dirty && !we_q;
    assign inc[6] = (state_q == LOOKUP) && !hit && vic_dirty &&  we_q;

    assign trans_count           = cnt_q[0];
    assign hit_load_count        = cnt_q[1];
    assign hit_store_count       = cnt_q[2];
    assign miss_load_count       = cnt_q[3];
    assign miss_store_count      = cnt_q[4];
    assign writeback_load_count  = cnt_q[5];
    assign writeback_store_count = cnt_q[6];

    // Tag compare across ways and victim choice: lowest invalid way, else round-robin pointer
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        vic_free = 1'b0;
        vic_way  = ptr_q[idx];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w] && !vic_free) begin
                vic_free = 1'b1;
                vic_way  = WW'(w);
            end
        end
        vic_dirty = valid_q[idx][vic_way] && dirty_q[idx][vic_way];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (in_data_req_i) state_d = LOOKUP;
            LOOKUP:    state_d = hit ? RESPOND : (vic_dirty ? WB_REQ : FILL_REQ);
            WB_REQ:    if (out_data_gnt_i) state_d = WB_WAIT;
            WB_WAIT:   if (out_data_rvalid_i) state_d = FILL_REQ;
            FILL_REQ:  if (out_data_gnt_i) state_d = FILL_WAIT;
            FILL_WAIT: if (out_data_rvalid_i) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode: memory-side fields are driven only while requesting, zero otherwise
    always_comb begin
        in_data_gnt_o    = grant;
        in_data_rvalid_o = (state_q == RESPOND);
        in_data_rdata_o  = rdata_q;
        out_data_req_o   = 1'b0;
        out_data_we_o    = 1'b0;
        out_data_be_o    = '0;
        out_data_addr_o  = '0;
        out_data_wdata_o = '0;
        case (state_q)
            WB_REQ: begin
                out_data_req_o   = 1'b1;
                out_data_we_o    = 1'b1;
                out_data_be_o    = '1;
                out_data_addr_o  = {tag_q[idx][way_q], idx, {OFF{1'b0}}};
                out_data_wdata_o = data_q[idx][way_q];
            end
            FILL_REQ: begin
                out_data_req_o  = 1'b1;
                out_data_be_o   = '1;
                out_data_addr_o = {waddr_q, {OFF{1'b0}}};
            end
            default: ;
        endcase
    end

    // Request latch and tag/data storage; validity lives in the reset block below
    always_ff @(posedge clk) begin
        if (grant) begin
            waddr_q <= in_data_addr_i[ADDR_WIDTH-1:OFF];
            we_q    <= in_data_we_i;
            be_q    <= in_data_be_i;
            wdata_q <= in_data_wdata_i;
        end
        if (state_q == LOOKUP) begin
            way_q  <= hit ? hit_way : vic_way;
            repl_q <= !hit && !vic_free;
            if (hit && we_q) data_q[idx][hit_way] <= merge_be(data_q[idx][hit_way], wdata_q, be_q);
        end
        if ((state_q == FILL_WAIT) && out_data_rvalid_i) begin
            tag_q[idx][way_q]  <= tag;
            data_q[idx][way_q] <= we_q ? merge_be(out_data_rdata_i, wdata_q, be_q) : out_data_rdata_i;
        end
    end

    // Valid/dirty bits, replacement pointers, load data and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            for (int unsigned c = 0; c < 7; c++) cnt_q[c] <= '0;
            rdata_q <= '0;
        end else begin
            if ((state_q == LOOKUP) && hit) begin
                if (we_q) dirty_q[idx][hit_way] <= 1'b1;
                else      rdata_q <= data_q[idx][hit_way];
            end
            if ((state_q == FILL_WAIT) && out_data_rvalid_i) begin
                valid_q[idx][way_q] <= 1'b1;
                dirty_q[idx][way_q] <= we_q;
                if (!we_q) rdata_q <= out_data_rdata_i;
                // pointer only moves when a live line was displaced
                if ((WAYS > 1) && repl_q) ptr_q[idx] <= ptr_q[idx] + 1'b1;
            end
            for (int unsigned c = 0; c < 7; c++) begin
                if (count_en_i && inc[c]) cnt_q[c] <= cnt_q[c] + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sayuru_sa.sv
// tb_sayuru_sa: randomized self-checking bench for sayuru_sa against an
// architectural memory image plus an abstract tag/replacement model.
module tb_sayuru_sa;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int SETS = 16;
    localparam int WAYS = 2;
    localparam int BEW  = DW / 8;
    localparam int OFF  = $clog2(BEW);
    localparam int NW   = 1 << (AW - OFF);

    logic           clk, rst;
    logic           in_data_req_i, in_data_gnt_o, in_data_rvalid_o;
    logic [AW-1:0]  in_data_addr_i;
    logic           in_data_we_i;
    logic [BEW-1:0] in_data_be_i;
    logic [DW-1:0]  in_data_wdata_i, in_data_rdata_o;
    logic           out_data_req_o, out_data_gnt_i, out_data_rvalid_i;
    logic [AW-1:0]  out_data_addr_o;
    logic           out_data_we_o;
    logic [BEW-1:0] out_data_be_o;
    logic [DW-1:0]  out_data_wdata_o, out_data_rdata_i;
    logic           count_en_i;
    logic [31:0]    trans_count, hit_load_count, hit_store_count, miss_load_count;
    logic [31:0]    miss_store_count, writeback_load_count, writeback_store_count;

    sayuru_sa #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst),
        .in_data_req_i(in_data_req_i), .in_data_gnt_o(in_data_gnt_o),
        .in_data_rvalid_o(in_data_rvalid_o), .in_data_addr_i(in_data_addr_i),
        .in_data_we_i(in_data_we_i), .in_data_be_i(in_data_be_i),
        .in_data_wdata_i(in_data_wdata_i), .in_data_rdata_o(in_data_rdata_o),
        .out_data_req_o(out_data_req_o), .out_data_gnt_i(out_data_gnt_i),
        .out_data_rvalid_i(out_data_rvalid_i), .out_data_addr_o(out_data_addr_o),
        .out_data_we_o(out_data_we_o), .out_data_be_o(out_data_be_o),
        .out_data_wdata_o(out_data_wdata_o), .out_data_rdata_i(out_data_rdata_i),
        .count_en_i(count_en_i),
        .trans_count(trans_count), .hit_load_count(hit_load_count),
        .hit_store_count(hit_store_count), .miss_load_count(miss_load_count),
        .miss_store_count(miss_store_count), .writeback_load_count(writeback_load_count),
        .writeback_store_count(writeback_store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Backing memory (what the interconnect holds) and architectural image (what loads must see)
    logic [DW-1:0] mem  [NW];
    logic [DW-1:0] gold [NW];

    // Abstract cache contents: which word addresses are resident, dirty, and where RR points
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int          m_tag   [SETS][WAYS];
    int          m_ptr   [SETS];
    int unsigned e_cnt   [7];

    logic [31:0] dut_cnt [7];
    string       cnt_name [7] = '{"trans", "hit_load", "hit_store", "miss_load",
                                  "miss_store", "wb_load", "wb_store"};
    assign dut_cnt[0] = trans_count;
    assign dut_cnt[1] = hit_load_count;
    assign dut_cnt[2] = hit_store_count;
    assign dut_cnt[3] = miss_load_count;
    assign dut_cnt[4] = miss_store_count;
    assign dut_cnt[5] = writeback_load_count;
    assign dut_cnt[6] = writeback_store_count;

    typedef struct {
        bit             we;
        logic [AW-1:0]  addr;
        logic [BEW-1:0] be;
        logic [DW-1:0]  wdata;
    } ev_t;
    ev_t ev_q[$];

    int g_lo = 0, g_hi = 0, r_lo = 0, r_hi = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < BEW; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] pk(input ev_t e);
        return 64'({e.we, e.addr, e.be, e.wdata});
    endfunction

    // Memory responder: random grant delay, random grant->rvalid delay, protocol checks
    bit          pend = 0, req_prev = 0, just_g = 0;
    int          gcnt = -1, rcnt = 0;
    logic [DW-1:0] rd;
    ev_t         held, cur;
    initial begin
        out_data_gnt_i = 1'b0; out_data_rvalid_i = 1'b0; out_data_rdata_i = '0;
        forever begin
            @(negedge clk);
            out_data_gnt_i    = 1'b0;
            out_data_rvalid_i = 1'b0;
            out_data_rdata_i  = $urandom;
            if (rst) begin
                pend = 0; gcnt = -1; req_prev = 0; just_g = 0;
            end else begin
                if (just_g) begin
                    check("mem_req_drop", 64'(out_data_req_o), 64'd0);
                    just_g = 0;
                end
                if (pend) begin
                    if (rcnt == 0) begin
                        out_data_rvalid_i = 1'b1;
                        out_data_rdata_i  = rd;
                        pend = 0;
                    end else rcnt--;
                end else if (out_data_req_o) begin
                    cur.we = out_data_we_o; cur.addr = out_data_addr_o;
                    cur.be = out_data_be_o; cur.wdata = out_data_wdata_o;
                    if (req_prev) check("mem_req_stable", pk(cur), pk(held));
                    held = cur; req_prev = 1;
                    if (gcnt < 0) gcnt = $urandom_range(g_hi, g_lo);
                    if (gcnt == 0) begin
                        out_data_gnt_i = 1'b1;
                        ev_q.push_back(cur);
                        if (cur.we) mem[cur.addr >> OFF] = merge(mem[cur.addr >> OFF], cur.wdata, cur.be);
                        else        rd = mem[cur.addr >> OFF];
                        pend = 1; rcnt = $urandom_range(r_hi, r_lo);
                        gcnt = -1; req_prev = 0; just_g = 1;
                    end else gcnt--;
                end
            end
        end
    end

    task automatic check_counters();
        for (int c = 0; c < 7; c++) check(cnt_name[c], 64'(dut_cnt[c]), 64'(e_cnt[c]));
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0; end
        end
        for (int c = 0; c < 7; c++) e_cnt[c] = 0;
        for (int i = 0; i < NW; i++) gold[i] = mem[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_data_req_i = 1'b0;
        @(negedge clk); #1;
        check("rst_out_req", 64'(out_data_req_o), 64'd0);
        check("rst_rvalid", 64'(in_data_rvalid_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        check("rst_out_fields", 64'({out_data_we_o, out_data_addr_o, out_data_be_o, out_data_wdata_o}), 64'd0);
        check("rst_rdata", 64'(in_data_rdata_o), 64'd0);
        check("rst_gnt", 64'(in_data_gnt_o), 64'd0);
        check_counters();
    endtask

    task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [BEW-1:0] be,
                          input logic [DW-1:0] wd, input bit ce);
        int s, t, wa, hw, vw, k, lat, mreq, wb_wa, n_exp;
        bit hit, wb, repl;
        logic [DW-1:0] exp_rd, wb_data;
        ev_t f;
        wa = int'(addr >> OFF); s = wa % SETS; t = wa / SETS;
        hit = 0; hw = 0; wb = 0; repl = 0; vw = -1; wb_wa = 0;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; hw = w; end
        if (!hit) begin
            for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && vw < 0) vw = w;
            if (vw < 0) begin repl = 1; vw = m_ptr[s]; end
            if (m_valid[s][vw] && m_dirty[s][vw]) begin wb = 1; wb_wa = m_tag[s][vw] * SETS + s; end
        end
        if (ce) begin
            e_cnt[0]++;
            e_cnt[hit ? (we ? 2 : 1) : (we ? 4 : 3)]++;
            if (wb) e_cnt[we ? 6 : 5]++;
        end
        exp_rd  = gold[wa];
        wb_data = gold[wb_wa];
        if (we) gold[wa] = merge(gold[wa], wd, be);
        if (hit) begin
            if (we) m_dirty[s][hw] = 1;
        end else begin
            if (repl) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            m_valid[s][vw] = 1; m_tag[s][vw] = t; m_dirty[s][vw] = we;
        end
        n_exp = hit ? 0 : (wb ? 2 : 1);

        @(negedge clk);
        check("rvalid_pulse", 64'(in_data_rvalid_o), 64'd0);
        ev_q.delete();
        count_en_i = ce; in_data_req_i = 1'b1; in_data_addr_i = addr;
        in_data_we_i = we; in_data_be_i = be; in_data_wdata_i = wd;
        k = 0; #1;
        while (!in_data_gnt_o && k < 20) begin @(negedge clk); #1; k++; end
        check("gnt_when_idle", 64'(k), 64'd0);
        lat = 0; mreq = -1;
        forever begin
            @(negedge clk); #1; lat++;
            if (mreq < 0 && out_data_req_o) mreq = lat;
            if (in_data_rvalid_o) break;
            check("gnt_while_busy", 64'(in_data_gnt_o), 64'd0);
            if (lat > 3000) begin check("rvalid_timeout", 64'(lat), 64'd0); break; end
        end
        in_data_req_i = 1'b0;
        if (hit) check("hit_latency", 64'(lat), 64'd2);
        else     check("miss_mem_req_cycle", 64'(mreq), 64'd2);
        if (!we) check("load_data", 64'(in_data_rdata_o), 64'(exp_rd));
        check("mem_op_count", 64'(ev_q.size()), 64'(n_exp));
        if (!hit && ev_q.size() == n_exp) begin
            if (wb) check("writeback_op", pk(ev_q[0]),
                          64'({1'b1, AW'(wb_wa << OFF), {BEW{1'b1}}, wb_data}));
            f = ev_q[n_exp-1];
            check("fill_op", 64'({f.we, f.addr, f.be}), 64'({1'b0, AW'(wa << OFF), {BEW{1'b1}}}));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wa, k;
        rst = 1'b1; in_data_req_i = 1'b0; in_data_addr_i = '0; in_data_we_i = 1'b0;
        in_data_be_i = '0; in_data_wdata_i = '0; count_en_i = 1'b1;
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        mem[16'h0040 >> OFF] = 32'hDEADBEEF;
        do_reset();

        // Fill, hit, partial store, then conflicting loads in the same set
        do_txn(0, 16'h0040, '1, '0, 1);
        do_txn(0, 16'h0040, '1, '0, 1);
        check("trans_after_2", 64'(trans_count), 64'd2);
        check("miss_load_after_2", 64'(miss_load_count), 64'd1);
        check("hit_load_after_2", 64'(hit_load_count), 64'd1);
        do_txn(1, 16'h0040, 4'b0011, 32'h0000AAAA, 1);
        do_txn(0, 16'h0040, '1, '0, 1);
        check("merged_load", 64'(in_data_rdata_o), 64'hDEADAAAA);
        do_txn(0, 16'h0080, '1, '0, 1);
        do_txn(0, 16'h00C0, '1, '0, 1);
        check_counters();

        // Slow memory: grant after 5 waits, rvalid 3 cycles after grant
        g_lo = 5; g_hi = 5; r_lo = 2; r_hi = 2;
        do_txn(1, 16'h0100, 4'b1100, 32'h12345678, 1);
        do_txn(0, 16'h0140, '1, '0, 1);
        do_txn(0, 16'h0180, '1, '0, 1);
        do_txn(0, 16'h01C0, '1, '0, 1);
        check_counters();

        // Random traffic over a few tags in a few sets to force conflicts
        g_lo = 0; g_hi = 3; r_lo = 0; r_hi = 3;
        repeat (300) begin
            wa = $urandom_range(5, 0) * SETS + $urandom_range(3, 0);
            do_txn(1'($urandom_range(1, 0)), AW'((wa << OFF) | $urandom_range(BEW-1, 0)),
                   BEW'($urandom), $urandom, ($urandom_range(9, 0) != 0));
        end
        check_counters();

        // Counters frozen while disabled
        repeat (4) begin
            wa = $urandom_range(5, 0) * SETS + $urandom_range(3, 0);
            do_txn(1'($urandom_range(1, 0)), AW'(wa << OFF), BEW'($urandom), $urandom, 0);
        end
        check_counters();

        // Reset while waiting on a fill
        g_lo = 0; g_hi = 0; r_lo = 6; r_hi = 6;
        do_txn(0, 16'h0200, '1, '0, 1);
        do_txn(0, 16'h0200, '1, '0, 1);
        @(negedge clk);
        ev_q.delete();
        in_data_req_i = 1'b1; in_data_addr_i = 16'h3000; in_data_we_i = 1'b0; in_data_be_i = '1;
        k = 0; #1;
        while (!in_data_gnt_o && k < 20) begin @(negedge clk); #1; k++; end
        check("abort_gnt", 64'(k), 64'd0);
        @(negedge clk);
        in_data_req_i = 1'b0;
        k = 0;
        while (ev_q.size() == 0 && k < 50) begin @(negedge clk); k++; end
        check("abort_fill_issued", 64'(ev_q.size()), 64'd1);
        do_reset();
        repeat (10) begin
            @(negedge clk); #1;
            check("abort_no_rvalid", 64'(in_data_rvalid_o), 64'd0);
        end
        g_lo = 0; g_hi = 2; r_lo = 0; r_hi = 2;
        do_txn(0, 16'h0200, '1, '0, 1);
        check("miss_after_reset", 64'(miss_load_count), 64'd1);
        check_counters();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
